// File: rtl/fb_line_fetch_if.sv
// Word-burst fetch bus between fb_line_fetch (master) and the frame-buffer memory (slave).
interface fb_line_fetch_if;
    logic        fetch_req;
    logic [39:0] fetch_addr;
    logic        fetch_ready;
    logic        fetch_rvalid;
    logic [31:0] fetch_rdata;

    modport master (
        output fetch_req,
        output fetch_addr,
        input  fetch_ready,
        input  fetch_rvalid,
        input  fetch_rdata
    );

    modport slave (
        input  fetch_req,
        input  fetch_addr,
        output fetch_ready,
        output fetch_rvalid,
        output fetch_rdata
    );
endinterface

// File: rtl/fb_line_fetch.sv
// Display line fetcher: two 256-byte line buffers refilled by 64-word bursts, with row prefetch.
// Define FB_MISS_COUNT_EN to add the saturating miss_count output.
module fb_line_fetch (
    input  logic                   clk_25mhz,
    input  logic                   rst,
    input  logic                   read_bytes,
    input  logic [39:0]            mem_addr,
    output logic [79:0]            input_bytes,
    output logic                   miss,
`ifdef FB_MISS_COUNT_EN
    output logic [15:0]            miss_count,
`endif
    fb_line_fetch_if.master        mem
);

    typedef enum logic [1:0] {StIdle, StFetch, StDone} state_e;

    state_e      state_q;
    logic [1:0]  valid_q;
    logic [8:0]  tag_q [2];
    logic        active_q;
    logic        target_q;
    logic [8:0]  fetch_tag_q;
    logic        pend_valid_q;
    logic [8:0]  pend_tag_q;
    logic [5:0]  issue_cnt_q;
    logic [5:0]  resp_cnt_q;
    logic [7:0]  line_mem [2][256];

    logic [8:0]  rd_tag;
    logic [7:0]  rd_off;
    logic [7:0]  pf_row;
    logic [8:0]  pf_tag;
    logic [8:0]  pend_tag_d;
    logic        hit_a, hit_b, hit, hit_idx;
    logic        rd_hit, rd_miss;
    logic        rd_busy, pf_busy, pf_present;
    logic        load_pend, start, active_d, wr_en;
    logic [79:0] rd_data;
    logic        unused_addr;

    assign unused_addr = ^mem_addr[39:17];

    always_comb begin
        rd_tag     = mem_addr[16:8];
        rd_off     = mem_addr[7:0];
        hit_a      = valid_q[0] && (tag_q[0] == rd_tag);
        hit_b      = valid_q[1] && (tag_q[1] == rd_tag);
        hit        = hit_a || hit_b;
        hit_idx    = ~hit_a;
        rd_hit     = read_bytes && hit;
        rd_miss    = read_bytes && !hit;
        pf_row     = (rd_tag[7:0] == 8'd239) ? 8'd0 : rd_tag[7:0] + 8'd1;
        pf_tag     = {rd_tag[8], pf_row};
        pf_present = (valid_q[0] && (tag_q[0] == pf_tag)) ||
                     (valid_q[1] && (tag_q[1] == pf_tag));
        // "In progress" covers a queued request as well as the line currently being filled.
        rd_busy    = (pend_valid_q && (pend_tag_q == rd_tag)) ||
                     ((state_q != StIdle) && (fetch_tag_q == rd_tag));
        pf_busy    = (pend_valid_q && (pend_tag_q == pf_tag)) ||
                     ((state_q != StIdle) && (fetch_tag_q == pf_tag));
        load_pend  = 1'b0;
        pend_tag_d = rd_tag;
        if (rd_miss && !rd_busy) begin
            load_pend = 1'b1;
        end else if (rd_hit && (rd_off == 8'd0) && !pf_present && !pf_busy) begin
            load_pend  = 1'b1;
            pend_tag_d = pf_tag;
        end
        active_d = rd_hit ? hit_idx : active_q;
        start    = (state_q == StIdle) && pend_valid_q;
        wr_en    = (state_q == StFetch) && mem.fetch_rvalid;
    end

    always_comb begin
        logic [8:0] idx;
        rd_data = '0;
        idx     = '0;
        for (int k = 0; k < 10; k++) begin
            idx = {1'b0, rd_off} + 9'(k);
            if (!idx[8]) begin
                rd_data[8*k +: 8] = line_mem[hit_idx][idx[7:0]];
            end
        end
    end

    always_ff @(posedge clk_25mhz) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                line_mem[target_q][{resp_cnt_q, 2'(b)}] <= mem.fetch_rdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk_25mhz) begin
        if (rst) begin
            state_q        <= StIdle;
            valid_q        <= '0;
            tag_q[0]       <= '0;
            tag_q[1]       <= '0;
            active_q       <= 1'b0;
            target_q       <= 1'b0;
            fetch_tag_q    <= '0;
            pend_valid_q   <= 1'b0;
            pend_tag_q     <= '0;
            issue_cnt_q    <= '0;
            resp_cnt_q     <= '0;
            input_bytes    <= '0;
            miss           <= 1'b0;
            mem.fetch_req  <= 1'b0;
            mem.fetch_addr <= '0;
`ifdef FB_MISS_COUNT_EN
            miss_count     <= '0;
`endif
        end else begin
            if (rd_hit) begin
                input_bytes <= rd_data;
            end else if (rd_miss) begin
                input_bytes <= '0;
                miss        <= 1'b1;
            end
`ifdef FB_MISS_COUNT_EN
            if (rd_miss && (miss_count != 16'hFFFF)) begin
                miss_count <= miss_count + 16'd1;
            end
`endif
            active_q <= active_d;
            if (start) begin
                pend_valid_q <= 1'b0;
            end
            // A new request in the same cycle as a launch overwrites the cleared slot.
            if (load_pend) begin
                pend_valid_q <= 1'b1;
                pend_tag_q   <= pend_tag_d;
            end

            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        target_q           <= ~active_d;
                        valid_q[~active_d] <= 1'b0;
                        fetch_tag_q        <= pend_tag_q;
                        issue_cnt_q        <= '0;
                        resp_cnt_q         <= '0;
                        mem.fetch_req      <= 1'b1;
                        mem.fetch_addr     <= {23'd0, pend_tag_q, 8'd0};
                        state_q            <= StFetch;
                    end
                end
                StFetch: begin
                    if (mem.fetch_req && mem.fetch_ready) begin
                        issue_cnt_q <= issue_cnt_q + 6'd1;
                        if (issue_cnt_q == 6'd63) begin
                            mem.fetch_req <= 1'b0;
                        end else begin
                            mem.fetch_addr[7:2] <= issue_cnt_q + 6'd1;
                        end
                    end
                    if (mem.fetch_rvalid) begin
                        resp_cnt_q <= resp_cnt_q + 6'd1;
                        if (resp_cnt_q == 6'd63) begin
                            state_q <= StDone;
                        end
                    end
                end
                StDone: begin
                    valid_q[target_q] <= 1'b1;
                    tag_q[target_q]   <= fetch_tag_q;
                    mem.fetch_req     <= 1'b0;
                    state_q           <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/fb_line_fetch.md
FB_LINE_FETCH -- requirements
Module: fb_line_fetch

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Ports SHALL be:
- clk_25mhz  in  1  pixel clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- read_bytes  in  1  display-side read strobe.
- mem_addr  in  40  display byte address {23'd0, fb, row[7:0], off[7:0]}; bits [39:17] ignored.
- input_bytes  out  80  read data; byte k at bits [8k+7:8k] = row byte off+k.
- fetch_req  out  1  memory word-request valid.
- fetch_addr  out  40  {23'd0, fb, row, word[5:0], 2'b00}.
- fetch_ready  in  1  memory accepts the request this cycle.
- fetch_rvalid  in  1  read word returned (in request order).
- fetch_rdata  in  32  word; bits [7:0] = lowest byte address.
- miss  out  1  sticky: a read found no valid line.

Function
REQ-003 Storage SHALL be two 256-byte line buffers (A/B), each with a tag {fb,row} and a valid bit; one buffer is "active", the other "shadow".
REQ-004 Read latency SHALL be exactly 1 cycle: read_bytes at cycle t -> input_bytes updated at t+1; input_bytes SHALL hold its value on cycles with no read.
REQ-005 Hit: the tag matches a valid buffer -> return bytes off..off+9 from it; bytes with off+k > 255 SHALL read 8'h00 (no wrap).
- Hit in shadow -> shadow becomes active at t+1.
REQ-006 Miss (no valid matching buffer): input_bytes SHALL be 80'h0 and miss SHALL set; if no fetch of that tag is in progress, the tag SHALL be loaded as the pending fetch.
REQ-007 Prefetch: any hit with off == 0 SHALL load the pending fetch with {fb, row+1}, where row 239 wraps to 0, unless that tag is already valid or being fetched.
REQ-008 Pending fetch SHALL be a single register; a newer request overwrites an older one not yet started.
REQ-009 Fetch FSM states SHALL be IDLE, FETCH, DONE.
- IDLE -> FETCH when a pending fetch exists: target = the non-active buffer, its valid bit is cleared, and the pending fetch is cleared.
- FETCH: fetch_req is held high while the issue count is < 64; the issue count advances only on fetch_req & fetch_ready.
- FETCH: the response count advances on fetch_rvalid, writing 4 bytes at word*4.
- FETCH -> DONE when the 64th response is received.
- DONE -> IDLE after 1 cycle, setting the target tag and its valid bit.
REQ-010 fetch_addr SHALL be word-incrementing from word 0 to 63; fetch_rvalid while IDLE SHALL be ignored.
REQ-011 A read on the same cycle as the DONE write SHALL see the old valid state (miss); it SHALL hit from the next cycle.
REQ-012 A read addressing the buffer under fill SHALL be a miss and SHALL NOT restart the fetch.
REQ-013 miss SHALL clear only on rst.

Reset
REQ-014 On rst, all outputs (input_bytes, fetch_req, fetch_addr, miss) SHALL be 0.
REQ-015 On rst, both valid bits SHALL clear, A SHALL become active, the pending fetch SHALL clear, and the FSM SHALL enter IDLE; a fetch in progress SHALL be aborted, and late responses SHALL be ignored.
REQ-016 Line buffer contents SHALL NOT require reset.

Configuration
REQ-017 Macro FB_MISS_COUNT_EN: when defined, add output miss_count (16 bits), which increments once per missed read, saturates at 16'hFFFF, and resets to 0; when undefined, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-018 After reset, read {fb=0,row=0,off=0} -> input_bytes 80'h0, miss=1, 64 fetch_req words at 0x0000..0x00FC.
REQ-019 Memory word n = {4{n[7:0]}}; after DONE, read off=0x05 -> input_bytes bytes = 01,01,01,02,02,02,02,03,03,03 (low byte first).
REQ-020 Read off=0xFA on a valid row -> bytes 0..5 from memory, bytes 6..9 = 00.
REQ-021 Hit row 5, off=0 -> prefetch addrs 0x0600..0x06FC; a later read of row 6 hits the shadow with no miss; row 239, off=0 -> prefetch row 0.
REQ-022 fetch_ready low 3 cycles mid-burst and rst pulse during FETCH -> fetch_addr holds while stalled; after rst, outputs are 0, both lines invalid, and stale fetch_rvalid writes nothing.
REQ-023 With FB_MISS_COUNT_EN defined, 3 misses then a hit -> miss_count = 3.
